// File: rtl/fila_param.sv
// Parametrised circular-buffer FIFO with prescaled operation ticks, full/empty
// flags, sticky overflow/underflow flags and a one-cycle data-valid strobe.
module fila_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int DIV   = 100
) (
  input  logic                       clock1M,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       enqueue_in,
  input  logic                       dequeue_in,
  input  logic                       clear_err_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out,
  output logic                       underflow_out,
  output logic                       tick_out
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV-1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(DEPTH);

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             enq_ok, deq_ok, ovf_set, unf_set;

  // With DIV=1 the counter is pinned at 0 and every cycle is a tick.
  assign tick     = (cnt == CNT_LAST);
  assign tick_out = tick;

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (cnt == CNT_LAST)  cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

  assign full_out  = (len_out == LEN_MAX);
  assign empty_out = (len_out == '0);

  // A full queue still takes an enqueue when a dequeue frees the head slot.
  assign deq_ok  = tick & dequeue_in & ~empty_out;
  assign enq_ok  = tick & enqueue_in & (~full_out | deq_ok);
  assign ovf_set = tick & enqueue_in & full_out & ~deq_ok;
  assign unf_set = tick & dequeue_in & empty_out;

  always_ff @(posedge clock1M) begin
    if (enq_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      len_out        <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= deq_ok;
      if (enq_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (deq_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (enq_ok && !deq_ok)      len_out <= len_out + LW'(1);
      else if (deq_ok && !enq_ok) len_out <= len_out - LW'(1);
    end
  end

  // Setting beats clearing when both land in the same cycle.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (ovf_set)           overflow_out  <= 1'b1;
      else if (clear_err_in) overflow_out  <= 1'b0;
      if (unf_set)           underflow_out <= 1'b1;
      else if (clear_err_in) underflow_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fila_param.sv
// Bench for fila_param: directed vector table, DIV=4 tick sequence, DEPTH=5 wrap
// with async reset, and randomized traffic against a shifting-array queue model.
module tb_fila_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instances a8 (DIV=1) and a4 (DIV=4) share one stimulus bus.
  logic [7:0]  din_a;
  logic        enq_a = 0, deq_a = 0, clr_a = 0;
  logic [7:0]  dout8, dout4;
  logic        v8, v4, full8, full4, emp8, emp4, ovf8, ovf4, unf8, unf4, tick8, tick4;
  logic [3:0]  len8, len4;

  logic [11:0] din5, dout5;
  logic        enq5 = 0, deq5 = 0, clr5 = 0;
  logic        v5, full5, emp5, ovf5, unf5, tick5;
  logic [2:0]  len5;

  fila_param #(.WIDTH(8), .DEPTH(8), .DIV(1)) u8 (
    .clock1M(clk), .reset(rst_n), .data_in(din_a), .enqueue_in(enq_a), .dequeue_in(deq_a),
    .clear_err_in(clr_a), .data_out(dout8), .data_valid_out(v8), .len_out(len8),
    .full_out(full8), .empty_out(emp8), .overflow_out(ovf8), .underflow_out(unf8), .tick_out(tick8));

  fila_param #(.WIDTH(8), .DEPTH(8), .DIV(4)) u4 (
    .clock1M(clk), .reset(rst_n), .data_in(din_a), .enqueue_in(enq_a), .dequeue_in(deq_a),
    .clear_err_in(clr_a), .data_out(dout4), .data_valid_out(v4), .len_out(len4),
    .full_out(full4), .empty_out(emp4), .overflow_out(ovf4), .underflow_out(unf4), .tick_out(tick4));

  fila_param #(.WIDTH(12), .DEPTH(5), .DIV(1)) u5 (
    .clock1M(clk), .reset(rst_n), .data_in(din5), .enqueue_in(enq5), .dequeue_in(deq5),
    .clear_err_in(clr5), .data_out(dout5), .data_valid_out(v5), .len_out(len5),
    .full_out(full5), .empty_out(emp5), .overflow_out(ovf5), .underflow_out(unf5), .tick_out(tick5));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 -> u8, 1 -> u4. Head is always element 0.
  logic [7:0] md [2][8];
  int ml[2], mc[2], mo[2], mu[2], mdo[2], mv[2];
  int mdiv[2] = '{1, 4};

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      ml[k] = 0; mc[k] = 0; mo[k] = 0; mu[k] = 0; mdo[k] = 0; mv[k] = 0;
    end
  endtask

  task automatic mstep(input int k, input logic e, input logic d, input logic c, input logic [7:0] di);
    bit t, so, su;
    t = (mc[k] == mdiv[k] - 1);
    so = 0; su = 0; mv[k] = 0;
    if (t && d) begin
      if (ml[k] > 0) begin
        mdo[k] = md[k][0];
        for (int i = 0; i < 7; i++) md[k][i] = md[k][i+1];
        ml[k]--; mv[k] = 1;
      end else su = 1;
    end
    if (t && e) begin
      if (ml[k] < 8) begin md[k][ml[k]] = di; ml[k]++; end
      else so = 1;
    end
    mo[k] = so ? 1 : (c ? 0 : mo[k]);
    mu[k] = su ? 1 : (c ? 0 : mu[k]);
    mc[k] = (mc[k] + 1) % mdiv[k];
  endtask

  task automatic cmpm(input int k, input int dout, input int v, input int len, input int full,
                      input int emp, input int ovf, input int unf, input int tick);
    chk($sformatf("m%0d_dout", k), dout, mdo[k]);
    chk($sformatf("m%0d_valid", k), v, mv[k]);
    chk($sformatf("m%0d_len", k), len, ml[k]);
    chk($sformatf("m%0d_full", k), full, int'(ml[k] == 8));
    chk($sformatf("m%0d_empty", k), emp, int'(ml[k] == 0));
    chk($sformatf("m%0d_ovf", k), ovf, mo[k]);
    chk($sformatf("m%0d_unf", k), unf, mu[k]);
    chk($sformatf("m%0d_tick", k), tick, int'(mc[k] == mdiv[k] - 1));
  endtask

  task automatic do_reset();
    rst_n = 0; enq_a = 0; deq_a = 0; clr_a = 0; din_a = 0;
    enq5 = 0; deq5 = 0; clr5 = 0; din5 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_len", len8, 0);   chk("rst_dout", dout8, 0); chk("rst_valid", v8, 0);
    chk("rst_empty", emp8, 1); chk("rst_full", full8, 0);
    chk("rst_ovf", ovf8, 0);   chk("rst_unf", unf8, 0);
    chk("rst_tick_div1", tick8, 1); chk("rst_tick_div4", tick4, 0);
    chk("rst_len5", len5, 0);
    rst_n = 1;
    mreset();
  endtask

  typedef struct {
    logic enq, deq, clr;
    logic [7:0] din, dout;
    logic v;
    int len;
    logic ovf, unf;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic e, input logic d, input logic c, input logic [7:0] di,
                      input logic [7:0] dout, input logic v, input int len, input logic o, input logic u);
    vec_t r;
    r.enq = e; r.deq = d; r.clr = c; r.din = di; r.dout = dout; r.v = v; r.len = len; r.ovf = o; r.unf = u;
    vecs.push_back(r);
  endtask

  task automatic step5(input logic e, input logic d, input logic [11:0] di);
    enq5 = e; deq5 = d; din5 = di;
    @(posedge clk); #1;
    enq5 = 0; deq5 = 0;
  endtask

  logic [11:0] v5exp [7];

  initial begin
    do_reset();

    // Directed table on the DIV=1, DEPTH=8 instance.
    addv(1,0,0,8'h11, 8'h00,0,1,0,0);
    addv(1,0,0,8'h22, 8'h00,0,2,0,0);
    addv(1,0,0,8'h33, 8'h00,0,3,0,0);
    addv(0,1,0,8'h00, 8'h11,1,2,0,0);
    addv(0,1,0,8'h00, 8'h22,1,1,0,0);
    addv(0,1,0,8'h00, 8'h33,1,0,0,0);
    addv(0,0,0,8'h00, 8'h33,0,0,0,0);
    for (int i = 1; i <= 8; i++) addv(1,0,0,8'(i), 8'h33,0,i,0,0);
    addv(1,0,0,8'hAA, 8'h33,0,8,1,0);
    for (int i = 1; i <= 8; i++) addv(0,1,0,8'h00, 8'(i),1,8-i,1,0);
    addv(0,0,1,8'h00, 8'h08,0,0,0,0);
    for (int i = 1; i <= 8; i++) addv(1,0,0,8'(i), 8'h08,0,i,0,0);
    addv(1,1,0,8'h99, 8'h01,1,8,0,0);
    for (int i = 2; i <= 8; i++) addv(0,1,0,8'h00, 8'(i),1,9-i,0,0);
    addv(0,1,0,8'h00, 8'h99,1,0,0,0);
    addv(0,1,0,8'h00, 8'h99,0,0,0,1);
    addv(1,1,0,8'h5C, 8'h99,0,1,0,1);
    addv(0,1,0,8'h00, 8'h5C,1,0,0,1);
    addv(0,0,1,8'h00, 8'h5C,0,0,0,0);
    addv(0,1,1,8'h00, 8'h5C,0,0,0,1);
    addv(0,0,1,8'h00, 8'h5C,0,0,0,0);
    foreach (vecs[i]) begin
      enq_a = vecs[i].enq; deq_a = vecs[i].deq; clr_a = vecs[i].clr; din_a = vecs[i].din;
      @(posedge clk); #1;
      chk($sformatf("v%0d_dout", i), dout8, vecs[i].dout);
      chk($sformatf("v%0d_valid", i), v8, vecs[i].v);
      chk($sformatf("v%0d_len", i), len8, vecs[i].len);
      chk($sformatf("v%0d_full", i), full8, int'(vecs[i].len == 8));
      chk($sformatf("v%0d_empty", i), emp8, int'(vecs[i].len == 0));
      chk($sformatf("v%0d_ovf", i), ovf8, vecs[i].ovf);
      chk($sformatf("v%0d_unf", i), unf8, vecs[i].unf);
    end

    // DIV=4: enqueue held from reset release, one acceptance per tick.
    do_reset();
    enq_a = 1; din_a = 8'h7E;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("d4_tick_c%0d", k), tick4, int'(k % 4 == 3));
      chk($sformatf("d4_len_c%0d", k), len4, k / 4);
    end
    enq_a = 0; deq_a = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("d4_dout", dout4, 8'h7E);

    // Randomized traffic on both DEPTH=8 instances against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int pe;
      pe = (n < 400) ? 70 : 30;
      enq_a = ($urandom_range(0, 99) < pe);
      deq_a = ($urandom_range(0, 99) < 100 - pe);
      clr_a = ($urandom_range(0, 99) < 5);
      din_a = 8'($urandom);
      mstep(0, enq_a, deq_a, clr_a, din_a);
      mstep(1, enq_a, deq_a, clr_a, din_a);
      @(posedge clk); #1;
      cmpm(0, dout8, v8, len8, full8, emp8, ovf8, unf8, tick8);
      cmpm(1, dout4, v4, len4, full4, emp4, ovf4, unf4, tick4);
    end

    // DEPTH=5, WIDTH=12: wrap across a non-power-of-two depth, then async reset.
    do_reset();
    for (int i = 0; i < 7; i++) v5exp[i] = 12'hA01 + 12'(i);
    for (int i = 0; i < 3; i++) step5(1, 0, v5exp[i]);
    for (int i = 0; i < 2; i++) begin
      step5(0, 1, 0);
      chk($sformatf("d5_pre_dout%0d", i), dout5, v5exp[i]);
    end
    for (int i = 3; i < 7; i++) step5(1, 0, v5exp[i]);
    chk("d5_len_full", len5, 5);
    chk("d5_full", full5, 1);
    step5(1, 0, 12'hFFF);
    chk("d5_ovf", ovf5, 1);
    chk("d5_len_after_ovf", len5, 5);
    for (int i = 2; i < 5; i++) begin
      step5(0, 1, 0);
      chk($sformatf("d5_dout%0d", i), dout5, v5exp[i]);
      chk($sformatf("d5_valid%0d", i), v5, 1);
    end
    chk("d5_len_mid", len5, 2);
    #2 rst_n = 0;
    #1;
    chk("d5_async_len", len5, 0);
    chk("d5_async_dout", dout5, 0);
    chk("d5_async_empty", emp5, 1);
    chk("d5_async_ovf", ovf5, 0);
    @(posedge clk); #1;
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fila_param.md
Name: fila_param

Overview:
- Parametrised successor to the fixed 8x8 queue: a circular-buffer FIFO with configurable data width and depth, clocked from clock1M.
- Operations are gated by an internal clock-enable prescaler, so the queue runs at the 10 kHz operation rate without a derived clock.
- Adds full/empty flags, simultaneous enqueue+dequeue, sticky overflow/underflow error flags and a data-valid strobe.
- Sits between the input capture logic and the downstream consumer.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 8, number of entries; any value >= 2, power of two not required.
- DIV, 100, clock1M cycles per operation tick; 100 gives 10 kHz; DIV=1 means a tick every cycle.

Ports:
- clock1M  in  1  system clock, 1 MHz.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  entry to enqueue.
- enqueue_in  in  1  enqueue request, sampled on tick cycles only.
- dequeue_in  in  1  dequeue request, sampled on tick cycles only.
- clear_err_in  in  1  synchronous clear of the sticky error flags, acts every cycle.
- data_out  out  WIDTH  last dequeued entry.
- data_valid_out  out  1  one-clock pulse: data_out was updated.
- len_out  out  $clog2(DEPTH+1)  number of occupied entries.
- full_out  out  1  len_out == DEPTH.
- empty_out  out  1  len_out == 0.
- overflow_out  out  1  sticky: enqueue was rejected because the queue was full.
- underflow_out  out  1  sticky: dequeue was rejected because the queue was empty.
- tick_out  out  1  current cycle is an operation tick.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, data_valid_out=0, len_out=0, overflow_out=0, underflow_out=0.
  - Read/write pointers = 0, prescaler count = 0.
  - empty_out=1, full_out=0, tick_out=0 (tick_out=1 if DIV=1).
  - Memory contents are don't-care.
  - Reset mid-operation discards all entries immediately. A pending tick is lost; counting restarts from 0 on release.
- Prescaler:
  - Counter runs 0..DIV-1 and wraps.
  - tick = (count == DIV-1), combinational from the counter; tick_out = tick.
  - First tick occurs DIV cycles after reset release.
- Requests:
  - On non-tick cycles, enqueue_in and dequeue_in are ignored. There is no request latching; upstream holds requests until tick_out.
- Enqueue (tick & enqueue_in):
  - Accepted if not full: mem[wr_ptr] <= data_in; wr_ptr advances modulo DEPTH (wraps DEPTH-1 -> 0).
  - If full and no dequeue: rejected, contents unchanged, overflow_out <= 1.
- Dequeue (tick & dequeue_in):
  - Accepted if not empty: data_out <= mem[rd_ptr] on that edge, so the value is visible in the cycle after the tick.
  - rd_ptr advances modulo DEPTH; data_valid_out = 1 for exactly that following cycle.
  - If empty: rejected, data_out holds, no valid pulse, underflow_out <= 1.
- Simultaneous enqueue and dequeue on a tick:
  - Not empty (including full): both accepted, len_out unchanged, no error. The dequeue reads the old head; the enqueue writes the tail.
  - Empty: enqueue accepted, dequeue rejected, underflow_out <= 1, len_out becomes 1. There is no write-through bypass.
- len_out:
  - +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- data_out holds its value between dequeues.
- Error flags:
  - Set and clear: clear_err_in=1 clears both flags.
  - If a set and clear_err_in occur in the same cycle, the set wins.
- full_out and empty_out are decoded from registered len_out; there is no extra latency.

Test Plan:
- DIV=1, reset, enqueue 0x11,0x22,0x33 on consecutive cycles -> len_out=3, empty_out=0; then dequeue x3 -> data_out=0x11,0x22,0x33, each valid one cycle after its request, then empty_out=1, len_out=0.
- DIV=1, fill 8 entries 0x01..0x08, then enqueue 0xAA -> full_out=1, overflow_out=1, len_out=8; dequeue x8 returns 0x01..0x08 with 0xAA absent; clear_err_in -> overflow_out=0.
- DIV=1, full queue, enqueue 0x99 with dequeue in the same cycle -> data_out=0x01, len_out stays 8, no overflow; after draining, the last entry is 0x99 (pointer wrap verified).
- DIV=1, empty queue, dequeue -> underflow_out=1, no data_valid_out, data_out unchanged; enqueue+dequeue of 0x5C while empty -> len_out=1, underflow_out=1, next dequeue returns 0x5C.
- DIV=4, hold enqueue_in=1 with data 0x7E from reset release -> tick_out high every 4th cycle; exactly one entry is accepted per tick, so len_out=1 after cycle 4 and len_out=2 after cycle 8.
- DIV=1, DEPTH=5, WIDTH=12: 3 enqueues, 2 dequeues, 4 enqueues -> len_out=5, full_out=1; drain order matches insertion order across the non-power-of-two wrap; assert reset low mid-drain -> len_out=0 and data_out=0 immediately, asynchronously.
